// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP encoding and the
// instruction-fetch FSM state type.
package rv32i_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_RESET_WAIT = 2'd0,
        FS_RUN        = 2'd1,
        FS_DRAIN      = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush; a push is accepted on a full
// FIFO only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// In-order instruction fetch with redirect flush and response discard.
// FETCH_MISALIGN_CHECK_EN adds fetch_misalign_o and halts on unaligned redirects.
module pc_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instruction_o,
    output logic            valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   w_redirect_pc;
    logic [XLEN-1:0]   w_pcq_head;
    logic [CW-1:0]     r_discard;
    logic [CW-1:0]     w_discard_next;
    logic [CW-1:0]     w_buf_count;
    logic [CW-1:0]     w_pcq_count;
    logic [SW-1:0]     w_inflight_next;
    logic [2*XLEN-1:0] w_buf_head;
    logic              w_buf_full;
    logic              w_buf_empty;
    logic              w_pcq_full;
    logic              w_pcq_empty;
    logic              w_halt;
    logic              w_room;
    logic              w_gnt;
    logic              w_push;
    logic              w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_halt;
    logic r_misalign;

    assign w_redirect_pc    = redirect_pc_i;
    assign w_halt           = r_halt;
    assign fetch_misalign_o = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_i & (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) r_halt <= (redirect_pc_i[1:0] != 2'b00);
        end
    end
`else
    assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
    assign w_halt        = 1'b0;
`endif

    // Outstanding requests are not counted separately: the live ones sit in the
    // PC queue and the abandoned ones in r_discard.
    assign w_room = (SW'(w_pcq_count) + SW'(r_discard) + SW'(w_buf_count)) < SW'(BUF_DEPTH);
    assign w_inflight_next = SW'(w_pcq_count) + SW'(r_discard) + SW'(w_gnt) - SW'(imem_rvalid_i);

    assign imem_addr_o = r_fetch_pc;
    assign w_gnt       = imem_req_o & imem_gnt_i;
    assign w_push      = imem_rvalid_i & (r_discard == '0) & ~redirect_i & ~w_pcq_empty;
    assign w_pop       = ~w_buf_empty & ~stall_i & ~redirect_i;

    always_comb begin
        w_discard_next = r_discard;
        if (redirect_i) begin
            w_discard_next = CW'(w_inflight_next);
        end else if (imem_rvalid_i && r_discard != '0) begin
            w_discard_next = r_discard - CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req_o   = 1'b0;
        case (r_state)
            FS_RESET_WAIT: w_state_next = FS_RUN;
            FS_RUN: begin
                imem_req_o   = ~redirect_i & w_room & ~w_halt;
                w_state_next = (w_discard_next != '0) ? FS_DRAIN : FS_RUN;
            end
            FS_DRAIN: w_state_next = (w_discard_next != '0) ? FS_DRAIN : FS_RUN;
            default:  w_state_next = FS_RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FS_RESET_WAIT;
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_i),
        .i_push  (w_gnt & ~w_pcq_full),
        .i_data  (r_fetch_pc),
        .i_pop   (w_push),
        .o_data  (w_pcq_head),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(BUF_DEPTH)) u_instr_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_i),
        .i_push  (w_push & (~w_buf_full | w_pop)),
        .i_data  ({w_pcq_head, imem_rdata_i}),
        .i_pop   (w_pop),
        .o_data  (w_buf_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    assign valid_o       = ~w_buf_empty;
    assign pc_o          = w_buf_head[2*XLEN-1:XLEN];
    assign instruction_o = valid_o ? w_buf_head[XLEN-1:0] : INSTR_NOP;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries, which is also the maximum number of outstanding requests.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port redirect_i  in  1  taken branch/jump; flush and restart fetch.
REQ-006 SHALL have port redirect_pc_i  in  32  redirect target.
REQ-007 SHALL have port stall_i  in  1  downstream IF/ID register not accepting.
REQ-008 SHALL have port imem_req_o  out  1  instruction memory request.
REQ-009 SHALL have port imem_addr_o  out  32  request address (word aligned).
REQ-010 SHALL have port imem_gnt_i  in  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i  in  1  response data valid; responses arrive in order, at least 1 cycle after grant.
REQ-012 SHALL have port imem_rdata_i  in  32  response instruction word.
REQ-013 SHALL have port pc_o  out  32  PC of the presented instruction.
REQ-014 SHALL have port instruction_o  out  32  presented instruction.
REQ-015 SHALL have port valid_o  out  1  pc_o/instruction_o valid for the IF/ID register.

Function
REQ-016 SHALL hold fetch_pc; imem_addr_o = fetch_pc; fetch_pc += 4 on each grant (imem_req_o & imem_gnt_i), wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-017 SHALL assert imem_req_o only when outstanding + buffer occupancy < BUF_DEPTH, no redirect is active this cycle, and the FSM is in RUN.
REQ-018 SHALL keep imem_req_o and imem_addr_o stable until granted.
REQ-019 SHALL push {request PC, imem_rdata_i} into the buffer on each non-discarded imem_rvalid_i; the request PC comes from an in-flight PC queue popped on rvalid.
REQ-020 SHALL drive valid_o = buffer not empty, with pc_o/instruction_o = head entry; the head pops when valid_o & !stall_i.
REQ-021 SHALL give a minimum latency of grant -> response cycle +1 to valid_o (buffer registered), i.e. 2 cycles from grant at zero memory wait.
REQ-022 SHALL run an FSM with states RESET_WAIT (first cycle after rst), RUN, and DRAIN. RESET_WAIT -> RUN unconditionally. RUN -> DRAIN on redirect with outstanding > 0. DRAIN -> RUN when the discard count reaches 0.
REQ-023 On redirect_i, SHALL in the same edge: empty the buffer and the PC queue, set fetch_pc = redirect_pc_i, set the discard count = outstanding, including any request granted in that same cycle.
REQ-024 SHALL drop, without pushing, responses arriving while the discard count > 0, decrementing the count on each one.
REQ-025 SHALL give redirect_i priority over stall_i, pop, push, and grant in the same cycle; valid_o SHALL be 0 the cycle after a redirect.
REQ-026 SHALL accept redirect_i while in DRAIN, adding any new grants to the discard count.
REQ-027 SHALL allow a simultaneous pop and push when the buffer is full, with occupancy unchanged.
REQ-028 SHALL never push to a full buffer; REQ-017 guarantees this.

Reset
REQ-029 On rst, SHALL set fetch_pc=RESET_PC, empty buffer and queue, outstanding=0, discard=0, FSM=RESET_WAIT, imem_req_o=0, valid_o=0.
REQ-030 SHALL make rst mid-operation abandon in-flight requests; imem is reset by the same rst and no response arrives afterwards.

Configuration
REQ-031 With macro FETCH_MISALIGN_CHECK_EN defined, SHALL add output fetch_misalign_o (1 bit), registered, pulsed for 1 cycle when redirect_i has redirect_pc_i[1:0] != 0. Fetch SHALL then halt (no requests) until the next redirect or rst.
REQ-032 Without FETCH_MISALIGN_CHECK_EN, SHALL force redirect_pc_i[1:0] to 2'b00, with no extra port.

Structure
REQ-033 SHALL take from shared package rv32i_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, and the fetch FSM state enum typedef.
REQ-034 SHALL use one sub-module, fetch_fifo: a parameterised synchronous FIFO (width, depth) with full/empty and a flush input, instantiated for the buffer (64-bit) and the PC queue (32-bit).

Verification
REQ-035 SHALL cover: reset release, imem grant every cycle, 1-cycle response -> addresses 0,4,8,...; valid_o first high 2 cycles after the first grant; pc_o 0,4,8 in order.
REQ-036 SHALL cover: stall_i held 5 cycles, buffer full -> imem_req_o low, outputs hold pc_o=8; on release the stream resumes at 12 with no loss or duplication.
REQ-037 SHALL cover: redirect_i to 32'h100 with 2 outstanding -> both responses dropped, next valid_o has pc_o=32'h100, FSM visits DRAIN.
REQ-038 SHALL cover: redirect_i in the same cycle as a grant and stall_i -> granted response discarded, fetch_pc=target, valid_o=0 next cycle.
REQ-039 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 SHALL cover, with FETCH_MISALIGN_CHECK_EN: redirect to 32'h102 -> fetch_misalign_o high 1 cycle, no further imem_req_o until redirect to 32'h200.
